// File: rtl/sdram_block_responder.sv
// Behavioural SDRAM block-fill responder: fixed first-access latency, then one cache line critical-word-first.
// Optional macro SDRAM_RESP_ABORT_EN: a request dropped during LATENCY aborts the transaction.
module sdram_block_responder #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32,
  parameter int MEM_WORDS   = 4096,
  parameter int T0_LATENCY  = 4,
  parameter int RECOVERY    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memReadRequest,
  input  logic [31:0]                    memReadAddress,
  output logic [WORD_SIZE-1:0]           memDataIn,
  output logic                           memDataReady,
  output logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
  output logic                           busy,
  input  logic                           load_en,
  input  logic [31:0]                    load_addr,
  input  logic [WORD_SIZE-1:0]           load_data
);

  localparam int IW      = $clog2(BLOCK_WORDS);
  localparam int AW      = $clog2(MEM_WORDS);
  localparam int CNT_MAX = (T0_LATENCY > RECOVERY) ? T0_LATENCY : RECOVERY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, LATENCY, BURST, RECOVER} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW:0]          beat_q;
  logic [AW-IW-1:0]     base_q;
  logic [IW-1:0]        start_q;
  logic                 rdy_q;
  logic [WORD_SIZE-1:0] data_q;
  logic [IW-1:0]        idx_q;
  logic                 busy_q;

  logic [WORD_SIZE-1:0] mem_q [MEM_WORDS];

  logic [AW-IW-1:0]     req_line;
  logic [IW-1:0]        req_start;
  logic [AW-IW-1:0]     rd_line_d;
  logic [IW-1:0]        rd_idx_d;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 abort_req;
  logic                 unused_addr_bits;

  assign req_line  = memReadAddress[AW+1:IW+2];
  assign req_start = memReadAddress[IW+1:2];
  assign unused_addr_bits = ^{memReadAddress[31:AW+2], memReadAddress[1:0],
                              load_addr[31:AW+2], load_addr[1:0]};

`ifdef SDRAM_RESP_ABORT_EN
  assign abort_req = !memReadRequest;
`else
  assign abort_req = 1'b0;
`endif

  // Word to present next cycle; in IDLE it comes straight from the incoming request (T0_LATENCY==1).
  always_comb begin
    rd_line_d = base_q;
    rd_idx_d  = start_q + beat_q[IW-1:0];
    if (state_q == IDLE) begin
      rd_line_d = req_line;
      rd_idx_d  = req_start;
    end
  end

  assign rd_word = mem_q[{rd_line_d, rd_idx_d}];

  // Backing store is never reset; a write at the read edge is seen only by later reads.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr[AW+1:2]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      start_q <= '0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (memReadRequest) begin
            base_q  <= req_line;
            start_q <= req_start;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (T0_LATENCY == 1) begin
              state_q <= BURST;
              rdy_q   <= 1'b1;
              idx_q   <= rd_idx_d;
              data_q  <= rd_word;
              beat_q  <= (IW+1)'(1);
            end else begin
              state_q <= LATENCY;
              beat_q  <= '0;
            end
          end
        end
        LATENCY: begin
          if (abort_req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(T0_LATENCY - 2)) begin
            state_q <= BURST;
            rdy_q   <= 1'b1;
            idx_q   <= rd_idx_d;
            data_q  <= rd_word;
            beat_q  <= beat_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BURST: begin
          if (beat_q == (IW+1)'(BLOCK_WORDS)) begin
            beat_q <= '0;
            cnt_q  <= '0;
            if (RECOVERY == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RECOVER;
            end
          end else begin
            rdy_q  <= 1'b1;
            idx_q  <= rd_idx_d;
            data_q <= rd_word;
            beat_q <= beat_q + 1'b1;
          end
        end
        RECOVER: begin
          if (cnt_q == CW'(RECOVERY - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memDataIn     = data_q;
  assign memDataReady  = rdy_q;
  assign memBlockIndex = idx_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sdram_block_responder.sv
// Directed bench for sdram_block_responder: per-cycle vector table plus back-to-back and abort sequences.
module tb_sdram_block_responder;

  localparam int BW  = 4;
  localparam int WS  = 32;
  localparam int MW  = 1024;
  localparam int T0  = 4;
  localparam int REC = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [31:0]   raddr;
  logic [WS-1:0] mdata;
  logic          mrdy;
  logic [1:0]    midx;
  logic          mbusy;
  logic          ld;
  logic [31:0]   laddr;
  logic [WS-1:0] ldat;

  int total = 0;
  int bad   = 0;

  logic [31:0] A [4];

  sdram_block_responder #(
    .BLOCK_WORDS(BW),
    .WORD_SIZE  (WS),
    .MEM_WORDS  (MW),
    .T0_LATENCY (T0),
    .RECOVERY   (REC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .memReadRequest(req),
    .memReadAddress(raddr),
    .memDataIn     (mdata),
    .memDataReady  (mrdy),
    .memBlockIndex (midx),
    .busy          (mbusy),
    .load_en       (ld),
    .load_addr     (laddr),
    .load_data     (ldat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ld;
    logic [31:0] laddr;
    logic [31:0] ldat;
    logic        rdy;
    logic [1:0]  idx;
    logic [31:0] data;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ten cycles: request in cycle 0, latency 1..3, burst 4..7, recovery 8, idle 9.
  task automatic add_req(input logic [31:0] addr, input logic [1:0] s,
                         input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    vec_t v;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int c = 0; c < 10; c++) begin
      v = '{rst: 1'b0, req: (c == 0), addr: addr, ld: 1'b0, laddr: '0, ldat: '0,
            rdy: 1'b0, idx: 2'd0, data: '0, busy: (c >= 1 && c <= 8)};
      if (c >= 4 && c <= 7) begin
        v.rdy  = 1'b1;
        v.idx  = s + 2'(c - 4);
        v.data = d[v.idx];
      end
      vq.push_back(v);
    end
  endtask

  initial begin
    int b;
    int r0, r1, nrdy;
    logic prev;
    logic busy9, busy2, busy3;
    logic [31:0] d4, d13;

    for (int k = 0; k < 4; k++) A[k] = 32'hA000_0000 + 32'(k);

    reset = 1'b1; req = 1'b0; raddr = '0; ld = 1'b0; laddr = '0; ldat = '0;
    for (int k = 0; k < 4; k++) begin
      ld = 1'b1; laddr = 32'h100 + 32'(4 * k); ldat = A[k];
      step();
    end
    ld = 1'b0;
    step();
    chk("reset rdy", 32'(mrdy), 32'd0);
    chk("reset data", mdata, 32'd0);
    chk("reset idx", 32'(midx), 32'd0);
    chk("reset busy", 32'(mbusy), 32'd0);
    reset = 1'b0;
    step();

    // Aligned line, then critical-word-first with a nonzero byte offset.
    add_req(32'h100, 2'd0, A[0], A[1], A[2], A[3]);
    add_req(32'h10B, 2'd2, A[0], A[1], A[2], A[3]);
    // Reset asserted in burst cycle 5 clears every output from cycle 6.
    b = vq.size();
    add_req(32'h100, 2'd0, A[0], A[1], A[2], A[3]);
    vq[b+5].rst = 1'b1;
    for (int c = 6; c < 10; c++) begin
      vq[b+c].rdy = 1'b0; vq[b+c].idx = 2'd0; vq[b+c].data = '0; vq[b+c].busy = 1'b0;
    end
    // Aliased address (above MEM_WORDS) after reset; load word 1 at the edge that reads it.
    b = vq.size();
    add_req(32'h0010_0100, 2'd0, A[0], A[1], A[2], A[3]);
    vq[b+4].ld = 1'b1; vq[b+4].laddr = 32'h104; vq[b+4].ldat = 32'hFFFF_FFFF;
    add_req(32'h100, 2'd0, A[0], 32'hFFFF_FFFF, A[2], A[3]);

    foreach (vq[i]) begin
      reset = vq[i].rst; req = vq[i].req; raddr = vq[i].addr;
      ld = vq[i].ld; laddr = vq[i].laddr; ldat = vq[i].ldat;
      chk($sformatf("v%0d rdy", i), 32'(mrdy), 32'(vq[i].rdy));
      chk($sformatf("v%0d idx", i), 32'(midx), 32'(vq[i].idx));
      chk($sformatf("v%0d data", i), mdata, vq[i].data);
      chk($sformatf("v%0d busy", i), 32'(mbusy), 32'(vq[i].busy));
      step();
    end
    reset = 1'b0; req = 1'b0; ld = 1'b0;
    step();

    // Request held high: second burst starts after recovery plus one idle sampling cycle.
    r0 = -1; r1 = -1; nrdy = 0; prev = 1'b0; busy9 = 1'b1; d4 = '0; d13 = '0;
    for (int c = 0; c < 26; c++) begin
      req = (c <= 16); raddr = 32'h10C;
      if (mrdy && !prev) begin
        if (r0 < 0) r0 = c;
        else if (r1 < 0) r1 = c;
      end
      if (mrdy) nrdy++;
      if (c == 9) busy9 = mbusy;
      if (c == 4) d4 = mdata;
      if (c == 13) d13 = mdata;
      prev = mrdy;
      step();
    end
    req = 1'b0;
    chk("b2b first word cycle", 32'(r0), 32'd4);
    chk("b2b second word cycle", 32'(r1), 32'd13);
    chk("b2b idle gap busy", 32'(busy9), 32'd0);
    chk("b2b ready cycles", 32'(nrdy), 32'd8);
    chk("b2b first data", d4, A[3]);
    chk("b2b second data", d13, A[3]);

    // Request dropped in cycle 2 while still in latency.
    nrdy = 0; busy2 = 1'b0; busy3 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req = (c < 2); raddr = 32'h104;
      if (mrdy) nrdy++;
      if (c == 2) busy2 = mbusy;
      if (c == 3) busy3 = mbusy;
      step();
    end
    chk("drop busy c2", 32'(busy2), 32'd1);
`ifdef SDRAM_RESP_ABORT_EN
    chk("abort ready cycles", 32'(nrdy), 32'd0);
    chk("abort busy c3", 32'(busy3), 32'd0);
`else
    chk("drop ready cycles", 32'(nrdy), 32'd4);
    chk("drop busy c3", 32'(busy3), 32'd1);
`endif
    chk("final idle busy", 32'(mbusy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
